cover_toggle_collector: RTL and testbench

COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

---
 rtl/cover_pkg.sv | 10 +
 rtl/cover_fifo.sv | 79 +++++++
 rtl/cover_toggle_collector.sv | 122 ++++++++++++
 tb/tb_cover_toggle_collector.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cover_pkg.sv
// Shared types for the toggle cover collector: the 64-bit cover index and
// the width of the saturating coalesce counter.
package cover_pkg;

    localparam int unsigned IDX_W      = 64;
    localparam int unsigned COALESCE_W = 16;

    typedef logic [IDX_W-1:0] cover_idx_t;

endpackage

// File: rtl/cover_fifo.sv
// Synchronous non-fallthrough FIFO holding reported cover indices.
// Ports:
//   clock, reset      clock and synchronous active-low reset
//   flush_i           drop all entries at the next edge (wins over push/pop)
//   push_i, data_i    write request and payload
//   pop_i             read request; the head is data_o
//   data_o            current head entry (valid when empty_o=0)
//   full_o, empty_o   registered occupancy flags
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module cover_fifo
    import cover_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       push_i,
    input  cover_idx_t data_i,
    input  logic       pop_i,
    output cover_idx_t data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cover_idx_t  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        do_push, do_pop;

    assign do_pop  = pop_i & ~empty_q;
    assign do_push = push_i & (~full_q | do_pop);

    // Next pointers and flags; flags are registered from the next pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (reset && !flush_i && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle coverage collector: records which of WIDTH cover points have been
// hit (sticky map), queues newly hit points (pending map), drains the lowest
// pending point per cycle into an output FIFO as COVER_INDEX+i.
// Ports:
//   clock, reset          clock and synchronous active-low reset
//   enable, clear         sample gate; flush all coverage state
//   valid[WIDTH]          per-point hit this cycle
//   out_valid/out_ready   output handshake; out_index is the reported index
//   hit_count             number of distinct points hit since clear
//   all_covered           every point has been hit
//   coalesce_count        saturating count of cycles with merged re-hits
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter int unsigned WIDTH       = 28,
    parameter cover_idx_t  COVER_INDEX = '0,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ONCE        = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output cover_idx_t                 out_index,
    output logic [$clog2(WIDTH+1)-1:0] hit_count,
    output logic                       all_covered,
    output logic [COALESCE_W-1:0]      coalesce_count
);

    localparam int unsigned CNT_W = $clog2(WIDTH+1);
    localparam int unsigned SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]      sticky_q, sticky_d;
    logic [WIDTH-1:0]      pending_q, pending_d;
    logic [WIDTH-1:0]      hit, set_mask, drain_mask, merged;
    logic [CNT_W-1:0]      hit_count_q, hit_count_d;
    logic                  all_covered_q;
    logic [COALESCE_W-1:0] coalesce_q, coalesce_d;
    logic [SEL_W-1:0]      sel_idx;
    logic                  sel_any;
    logic                  fifo_full, fifo_empty;
    logic                  pop, drain;

    // Lowest-numbered pending point wins.
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_any = 1'b1;
                sel_idx = SEL_W'(i);
            end
        end
    end

    assign pop        = ~fifo_empty & out_ready;
    // A full FIFO still accepts a push when it is popped in the same cycle.
    assign drain      = sel_any & (~fifo_full | pop) & ~clear;
    assign drain_mask = drain ? (WIDTH'(1) << sel_idx) : '0;

    // Coverage state update; clear overrides every other effect.
    always_comb begin
        hit      = (enable && !clear) ? valid : '0;
        set_mask = (ONCE != 0) ? (hit & ~sticky_q) : hit;
        // A hit on a bit being drained this cycle re-arms it, not a merge.
        merged   = (ONCE != 0) ? '0 : (hit & pending_q & ~drain_mask);

        sticky_d    = clear ? '0 : (sticky_q | hit);
        pending_d   = clear ? '0 : ((pending_q & ~drain_mask) | set_mask);

        coalesce_d = coalesce_q;
        if (clear) begin
            coalesce_d = '0;
        end else if ((|merged) && (coalesce_q != '1)) begin
            coalesce_d = coalesce_q + COALESCE_W'(1);
        end

        hit_count_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit_count_d = hit_count_d + CNT_W'(sticky_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sticky_q      <= '0;
            pending_q     <= '0;
            hit_count_q   <= '0;
            all_covered_q <= 1'b0;
            coalesce_q    <= '0;
        end else begin
            sticky_q      <= sticky_d;
            pending_q     <= pending_d;
            hit_count_q   <= hit_count_d;
            all_covered_q <= (hit_count_d == CNT_W'(WIDTH));
            coalesce_q    <= coalesce_d;
        end
    end

    cover_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (clear),
        .push_i  (drain),
        .data_i  (COVER_INDEX + IDX_W'(sel_idx)),
        .pop_i   (pop),
        .data_o  (out_index),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid      = ~fifo_empty;
    assign hit_count      = hit_count_q;
    assign all_covered    = all_covered_q;
    assign coalesce_count = coalesce_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Scoreboard bench: instance a runs ONCE=1, instance b runs ONCE=0.
// Expected indices are queued when stimulus is issued; per-instance monitors
// compare every accepted output against the queue head.
module tb_cover_toggle_collector;
    import cover_pkg::*;

    logic clock;
    logic reset;

    logic        a_en, a_clr, a_rdy, a_ov, a_ac;
    logic [27:0] a_vld;
    cover_idx_t  a_idx;
    logic [4:0]  a_hc;
    logic [15:0] a_cc;

    logic        b_en, b_clr, b_rdy, b_ov, b_ac;
    logic [27:0] b_vld;
    cover_idx_t  b_idx;
    logic [4:0]  b_hc;
    logic [15:0] b_cc;

    cover_idx_t exp_a[$];
    cover_idx_t exp_b[$];
    int n_checks;
    int n_pass;

    cover_toggle_collector #(
        .WIDTH(28), .COVER_INDEX(64'd100), .FIFO_DEPTH(4), .ONCE(1)
    ) u_a (
        .clock(clock), .reset(reset), .enable(a_en), .clear(a_clr),
        .valid(a_vld), .out_valid(a_ov), .out_ready(a_rdy), .out_index(a_idx),
        .hit_count(a_hc), .all_covered(a_ac), .coalesce_count(a_cc)
    );

    cover_toggle_collector #(
        .WIDTH(28), .COVER_INDEX(64'd100), .FIFO_DEPTH(4), .ONCE(0)
    ) u_b (
        .clock(clock), .reset(reset), .enable(b_en), .clear(b_clr),
        .valid(b_vld), .out_valid(b_ov), .out_ready(b_rdy), .out_index(b_idx),
        .hit_count(b_hc), .all_covered(b_ac), .coalesce_count(b_cc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, act, exp);
    endtask

    // Monitors: outputs are accepted on out_valid & out_ready.
    always @(negedge clock) begin
        if (reset && a_ov && a_rdy) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_a got=%0d want=none", a_idx);
            end else begin
                check("out_a", a_idx, exp_a.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (reset && b_ov && b_rdy) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_b got=%0d want=none", b_idx);
            end else begin
                check("out_b", b_idx, exp_b.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain_a(input string name);
        for (int k = 0; k < 200 && exp_a.size() != 0; k++) tick();
        tick();
        check(name, exp_a.size(), 0);
    endtask

    task automatic drain_b(input string name);
        for (int k = 0; k < 200 && exp_b.size() != 0; k++) tick();
        tick();
        check(name, exp_b.size(), 0);
    endtask

    task automatic clear_a();
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0;
        a_en = 0; a_clr = 0; a_rdy = 0; a_vld = '0;
        b_en = 0; b_clr = 0; b_rdy = 0; b_vld = '0;
        tick();
        tick();
        check("rst_ov_a", a_ov, 0);
        check("rst_hc_a", a_hc, 0);
        check("rst_ac_a", a_ac, 0);
        check("rst_cc_b", b_cc, 0);
        check("rst_ov_b", b_ov, 0);
        reset = 1'b1;
        tick();

        // Two hits in one cycle: 100 at N+2, 102 at N+3.
        a_rdy = 1; a_en = 1;
        exp_a.push_back(64'd100);
        exp_a.push_back(64'd102);
        a_vld = 28'h0000005;
        tick();
        a_vld = '0;
        check("lat_n1_ov", a_ov, 0);
        tick();
        check("lat_n2_ov", a_ov, 1);
        check("lat_n2_idx", a_idx, 100);
        tick();
        check("lat_n3_idx", a_idx, 102);
        check("lat_hc", a_hc, 2);
        repeat (3) tick();
        clear_a();
        check("clr_hc", a_hc, 0);
        check("clr_ov", a_ov, 0);

        // Held hit reported once.
        exp_a.push_back(64'd103);
        a_vld = 28'h0000008;
        repeat (10) tick();
        a_vld = '0;
        repeat (4) tick();
        check("hold_hc", a_hc, 1);
        check("hold_q", exp_a.size(), 0);
        clear_a();

        // All points at once with backpressure.
        a_rdy = 0;
        for (int i = 0; i < 28; i++) exp_a.push_back(64'(100 + i));
        a_vld = 28'hFFFFFFF;
        tick();
        a_vld = '0;
        repeat (6) tick();
        check("bp_ov", a_ov, 1);
        check("bp_idx0", a_idx, 100);
        tick();
        check("bp_idx_stable", a_idx, 100);
        check("bp_ac", a_ac, 1);
        check("bp_hc", a_hc, 28);
        a_rdy = 1;
        drain_a("bp_drain");
        check("bp_ac_after", a_ac, 1);
        check("bp_ov_after", a_ov, 0);
        clear_a();
        check("bp_clr_ac", a_ac, 0);

        // Clear wins over a simultaneous hit.
        a_clr = 1; a_vld = 28'h0000002;
        tick();
        a_clr = 0; a_vld = '0;
        check("clrhit_ov", a_ov, 0);
        check("clrhit_hc", a_hc, 0);
        repeat (4) tick();
        check("clrhit_ov_late", a_ov, 0);

        // ONCE=0: re-hits on a stalled pending bit are merged.
        b_en = 1; b_rdy = 0;
        for (int i = 0; i < 4; i++) exp_b.push_back(64'(100 + i));
        b_vld = 28'h000000F;
        tick();
        b_vld = '0;
        repeat (6) tick();
        check("coal_full_ov", b_ov, 1);
        exp_b.push_back(64'd105);
        b_vld = 28'h0000020;
        repeat (3) tick();
        b_vld = '0;
        tick();
        check("coal_cc", b_cc, 2);
        b_rdy = 1;
        drain_b("coal_drain");
        check("coal_hc", b_hc, 5);

        // ONCE=0: separated re-hits each report.
        exp_b.push_back(64'd107);
        exp_b.push_back(64'd107);
        b_vld = 28'h0000080;
        tick();
        b_vld = '0;
        repeat (5) tick();
        b_vld = 28'h0000080;
        tick();
        b_vld = '0;
        drain_b("rehit_drain");
        check("rehit_hc", b_hc, 6);

        // ONCE=0: hit coinciding with drain of the same bit re-arms it.
        repeat (3) exp_b.push_back(64'd109);
        b_vld = 28'h0000200;
        repeat (3) tick();
        b_vld = '0;
        drain_b("hitdrain_drain");
        check("hitdrain_cc", b_cc, 2);
        check("hitdrain_hc", b_hc, 7);

        // Reset discards queued entries.
        a_rdy = 0;
        a_vld = 28'h0000007;
        tick();
        a_vld = '0;
        repeat (5) tick();
        check("rstq_ov_before", a_ov, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rstq_ov", a_ov, 0);
        check("rstq_hc", a_hc, 0);
        check("rstq_ac", a_ac, 0);
        a_rdy = 1;
        repeat (8) tick();
        check("rstq_ov_late", a_ov, 0);

        check("end_q_a", exp_a.size(), 0);
        check("end_q_b", exp_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
